// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and colour types for the fractal write side and scan-out read side.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 7;
    localparam int unsigned MAX_ITER = 100;
    localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int unsigned PIX_W    = 10;
    localparam int unsigned COLOR_W  = 12;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(FB_DEPTH - H_ACTIVE);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Frame-buffer read port B: address/enable out from the scan-out, count data back.
interface fb_rd_if;
    import fb_pkg::*;

    logic [ADDR_W-1:0] addr_r;
    logic              rd_en;
    logic [DATA_W-1:0] dout_r;

    modport master (output addr_r, output rd_en, input dout_r);
    modport slave  (input addr_r, input rd_en, output dout_r);

endinterface

// File: rtl/iter_palette.sv
// Maps a stored iteration count to a 12-bit RGB colour; counts at or above MAX_ITER are inside the set.
module iter_palette
    import fb_pkg::*;
(
    input  logic [DATA_W-1:0] iter,
    output rgb_t              color_c
);

    always_comb begin
        color_c = '0;
        if (iter >= DATA_W'(MAX_ITER)) begin
            color_c = '0;
        end else if (iter == '0) begin
            color_c = '{r: 4'hF, g: 4'hF, b: 4'hF};
        end else begin
            color_c.r = iter[3:0];
            color_c.g = iter[5:2];
            color_c.b = ~iter[3:0];
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Walks the frame buffer in raster order in step with vga_sync and turns each count into a colour.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic               Clk_100M,
    input  logic               reset_n,
    input  logic               pixel_tick,
    input  logic               video_on,
    input  logic [PIX_W-1:0]   pixel_x,
    input  logic [PIX_W-1:0]   pixel_y,
    fb_rd_if.master            rd,
    output logic [COLOR_W-1:0] color,
    output logic               frame_start,
    output logic               overrun
);

    localparam int unsigned PIPE_W = RD_LAT + 1;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic [ADDR_W-1:0]  line_next;
    logic               rd_en_q, rd_en_d;
    logic               frame_start_q, frame_start_d;
    logic               overrun_q, overrun_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [PIPE_W-1:0]  vld_q, vld_d;
    logic [PIPE_W-1:0]  blank_q, blank_d;
    rgb_t               pal_c;

    iter_palette u_palette (
        .iter    (rd.dout_r),
        .color_c (pal_c)
    );

    // Next line start saturates so a reset mid-frame can never walk past the last line.
    always_comb begin
        line_next = line_base_q;
        if (line_base_q < LINE_LAST) begin
            line_next = line_base_q + LINE_STEP;
        end
    end

    always_comb begin
        addr_d        = addr_q;
        line_base_d   = line_base_q;
        rd_en_d       = 1'b0;
        frame_start_d = 1'b0;
        overrun_d     = overrun_q;
        color_d       = color_q;
        vld_d         = {vld_q[RD_LAT-1:0], 1'b0};
        blank_d       = {blank_q[RD_LAT-1:0], 1'b0};

        if (vld_q[RD_LAT]) begin
            color_d = blank_q[RD_LAT] ? '0 : COLOR_W'(pal_c);
        end

        // A new tick flushes any fetch still in flight; only the newest one completes.
        if (pixel_tick) begin
            if (|vld_q) begin
                overrun_d = 1'b1;
            end
            vld_d   = PIPE_W'(1);
            blank_d = PIPE_W'(!video_on);

            if (video_on) begin
                rd_en_d = 1'b1;
                if (pixel_x == '0 && pixel_y == '0) begin
                    addr_d        = '0;
                    line_base_d   = '0;
                    frame_start_d = 1'b1;
                end else if (pixel_x == '0) begin
                    line_base_d = line_next;
                    addr_d      = line_next;
                end else if (addr_q < ADDR_LAST) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            line_base_q   <= '0;
            rd_en_q       <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            color_q       <= '0;
            vld_q         <= '0;
            blank_q       <= '0;
        end else begin
            addr_q        <= addr_d;
            line_base_q   <= line_base_d;
            rd_en_q       <= rd_en_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            color_q       <= color_d;
            vld_q         <= vld_d;
            blank_q       <= blank_d;
        end
    end

    assign rd.addr_r   = addr_q;
    assign rd.rd_en    = rd_en_q;
    assign color       = color_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a buffer model feeds counts, expected reads and colours are queued per tick.
module tb_fb_scanout;
    import fb_pkg::*;

    localparam int unsigned RD_LAT = 2;

    typedef struct {
        int unsigned cyc;
        int unsigned addr;
        bit          fs;
    } rd_exp_t;

    typedef struct {
        int unsigned due;
        int unsigned col;
    } col_exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pixel_tick = 1'b0;
    logic               video_on = 1'b0;
    logic [PIX_W-1:0]   pixel_x = '0;
    logic [PIX_W-1:0]   pixel_y = '0;
    logic [COLOR_W-1:0] color;
    logic               frame_start;
    logic               overrun;

    fb_rd_if rd_bus ();

    fb_scanout #(.RD_LAT(RD_LAT)) dut (
        .Clk_100M    (clk),
        .reset_n     (rst_n),
        .pixel_tick  (pixel_tick),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .rd          (rd_bus.master),
        .color       (color),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Buffer model: count is a fixed function of address unless a test overrides it.
    bit                ovr_en = 1'b0;
    int unsigned       ovr_val = 0;
    logic [DATA_W-1:0] bpipe [RD_LAT];

    function automatic int unsigned data_fn(input int unsigned a);
        return (a ^ (a >> 7)) & 32'd127;
    endfunction

    always @(posedge clk) begin
        if (rd_bus.rd_en)
            bpipe[0] <= DATA_W'(ovr_en ? ovr_val : data_fn(32'(rd_bus.addr_r)));
        for (int i = 1; i < RD_LAT; i++) bpipe[i] <= bpipe[i-1];
    end
    assign rd_bus.dout_r = bpipe[RD_LAT-1];

    function automatic int unsigned ref_pal(input int unsigned d);
        if (d >= 100) return 32'h000;
        if (d == 0)   return 32'hFFF;
        return ((d % 16) << 8) | (((d / 4) % 16) << 4) | (15 - (d % 16));
    endfunction

    rd_exp_t     rdq[$];
    col_exp_t    colq[$];
    int unsigned cur_col  = 0;
    int unsigned m_addr   = 0;
    int unsigned m_line   = 0;
    int unsigned last_due = 0;
    bit          exp_ovr  = 1'b0;

    // Drives one tick at the current negedge and queues what the DUT must produce for it.
    task automatic tick(input int unsigned x, input int unsigned y, input bit von,
                        input int unsigned gap = 4);
        int unsigned n;
        int unsigned col;
        bit          fs;
        check("overrun_pre_tick", 32'(overrun), 32'(exp_ovr));
        n  = cyc + 1;
        fs = 1'b0;
        if (last_due >= n) exp_ovr = 1'b1;
        while (colq.size() > 0 && colq[$].due > n) void'(colq.pop_back());
        if (von) begin
            if (x == 0 && y == 0) begin
                m_line = 0;
                m_addr = 0;
                fs     = 1'b1;
            end else if (x == 0) begin
                if (m_line < FB_DEPTH - H_ACTIVE) m_line += H_ACTIVE;
                m_addr = m_line;
            end else if (m_addr < FB_DEPTH - 1) begin
                m_addr++;
            end
            rdq.push_back('{cyc: n, addr: m_addr, fs: fs});
            col = ref_pal(ovr_en ? ovr_val : data_fn(m_addr));
        end else begin
            col = 0;
        end
        colq.push_back('{due: n + RD_LAT + 1, col: col});
        last_due   = n + RD_LAT + 1;
        pixel_x    = PIX_W'(x);
        pixel_y    = PIX_W'(y);
        video_on   = von;
        pixel_tick = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Holds reset for a number of clocks with ticks still arriving; outputs must sit at reset values.
    task automatic do_reset(input int unsigned clocks);
        rst_n = 1'b0;
        rdq.delete();
        colq.delete();
        cur_col  = 0;
        m_addr   = 0;
        m_line   = 0;
        last_due = 0;
        exp_ovr  = 1'b0;
        video_on = 1'b1;
        for (int i = 0; i < int'(clocks); i++) begin
            pixel_tick = (i % 4 == 0);
            pixel_x    = PIX_W'(i);
            pixel_y    = PIX_W'(3);
            @(negedge clk);
            check("rst_color", 32'(color), 32'h000);
            check("rst_rd_en", 32'(rd_bus.rd_en), 32'd0);
            check("rst_addr", 32'(rd_bus.addr_r), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_frame_start", 32'(frame_start), 32'd0);
        end
        pixel_tick = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compares read strobes and colour updates against the queues on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
                check("rd_en", 32'(rd_bus.rd_en), 32'd1);
                check("addr_r", 32'(rd_bus.addr_r), rdq[0].addr);
                check("frame_start", 32'(frame_start), 32'(rdq[0].fs));
                void'(rdq.pop_front());
            end else begin
                check("rd_en_idle", 32'(rd_bus.rd_en), 32'd0);
                check("frame_start_idle", 32'(frame_start), 32'd0);
            end
            if (colq.size() > 0 && colq[0].due == cyc) begin
                cur_col = colq[0].col;
                void'(colq.pop_front());
                check("color", 32'(color), cur_col);
            end else if (colq.size() > 0 && colq[0].due == cyc + 1) begin
                check("color_hold", 32'(color), cur_col);
            end
        end
    end

    int unsigned pal_in  [5] = '{100, 127, 0, 5, 37};
    int unsigned pal_out [5] = '{32'h000, 32'h000, 32'hFFF, 32'h51A, 32'h59A};
    int unsigned saved_addr;

    initial begin
        @(negedge clk);
        do_reset(10);

        // Row walk from the origin
        tick(0, 0, 1'b1);
        tick(1, 0, 1'b1);
        tick(2, 0, 1'b1);

        // Finish row 0, step down through every line, then finish the last row
        for (int x = 3; x < 640; x++) tick(x, 0, 1'b1);
        check("addr_639", 32'(rd_bus.addr_r), 32'd639);
        tick(0, 1, 1'b1);
        check("addr_640", 32'(rd_bus.addr_r), 32'd640);
        for (int y = 2; y < 480; y++) tick(0, y, 1'b1);
        check("addr_306560", 32'(rd_bus.addr_r), 32'd306560);
        for (int x = 1; x < 640; x++) tick(x, 479, 1'b1);
        check("addr_307199", 32'(rd_bus.addr_r), 32'd307199);
        tick(5, 479, 1'b1);
        check("addr_saturate", 32'(rd_bus.addr_r), 32'd307199);

        // Palette corners via forced buffer data
        tick(0, 0, 1'b1);
        ovr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ovr_val = pal_in[i];
            tick(i + 1, 0, 1'b1);
            check("palette", 32'(color), pal_out[i]);
        end

        // Blanked tick after a coloured pixel
        saved_addr = 32'(rd_bus.addr_r);
        tick(0, 0, 1'b0);
        check("blank_addr", 32'(rd_bus.addr_r), saved_addr);
        check("blank_color", 32'(color), 32'h000);
        ovr_en = 1'b0;

        // Back-to-back ticks, then sticky overrun, then reset mid-frame
        tick(6, 0, 1'b1, 1);
        tick(7, 0, 1'b1);
        check("overrun_set", 32'(overrun), 32'd1);
        tick(8, 0, 1'b1);
        tick(9, 0, 1'b1);
        check("overrun_sticky", 32'(overrun), 32'd1);
        do_reset(3);
        check("post_rst_overrun", 32'(overrun), 32'd0);
        check("post_rst_color", 32'(color), 32'h000);
        tick(10, 7, 1'b1);
        check("post_rst_addr", 32'(rd_bus.addr_r), 32'd1);
        repeat (4) @(negedge clk);

        check("rd_queue_drained", 32'(rdq.size()), 32'd0);
        check("col_queue_drained", 32'(colq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
